rhd_seq_ctrl: RTL and testbench
===============================

RHD_SEQ_CTRL -- requirements
Module: rhd_seq_ctrl

Interface
REQ-001 Parameter NUM_CH, default 32, meaning amplifier channels converted per frame, legal 1..32.
REQ-002 Parameter SCK_DIV, default 2, meaning clk cycles per SCK half-period, legal >=1.
REQ-003 Parameter CS_GAP, default 4, meaning clk cycles CS held high between SPI words, legal >=2.
REQ-004 Parameter PWRUP_CYC, default 2000, meaning clk cycles waited after start before the first SPI word.
REQ-005 Parameter N_INIT, default 18, meaning number of register-write words in the init sequence, legal 1..64.
REQ-006 Ports, listed as name, direction, width, meaning:
- clk  in  1  single clock (20 MHz); reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- start  in  1  level-sampled request to begin operation when IDLE.
- stop  in  1  request to end sampling at the next frame boundary.
- mode  in  1  0 = continuous frames, 1 = single frame; sampled on leaving IDLE.
- init_idx  out  6  index of the init word requested.
- init_word  in  16  init command for init_idx, combinational from the parent.
- rhd_cs  out  1  SPI chip select, active low.
- rhd_sck  out  1  SPI clock, idle low.
- rhd_mosi  out  1  SPI data to chip, MSB first.
- rhd_miso  in  1  SPI data from chip.
- init_done  out  1  init and calibration complete.
- busy  out  1  high in any state except IDLE.
- smp_data  out  16  received ADC word.
- smp_ch  out  5  channel of smp_data.
- smp_valid  out  1  one-cycle strobe qualifying smp_data and smp_ch; no backpressure.
- frame_start  out  1  high with the smp_valid of channel 0.

Function
REQ-007 FSM states SHALL be IDLE, PWRUP, INIT, CAL, SAMPLE.
REQ-008 IDLE with start=1 SHALL go to PWRUP if init_done=0, else to SAMPLE.
REQ-009 PWRUP SHALL count PWRUP_CYC cycles with CS high, then go to INIT.
REQ-010 INIT SHALL send init_word for init_idx = 0..N_INIT-1, one word each, then go to CAL.
REQ-011 CAL SHALL send CALIBRATE 0x5500 followed by 9 dummy words 0xFF00, set init_done, then go to SAMPLE.
REQ-012 SAMPLE frame SHALL be NUM_CH+2 words: CONVERT(c) = {2'b00, c[5:0], 8'h00} for c = 0..NUM_CH-1, then two 0xFF00 pad words.
REQ-013 Word k of a frame, for 2 <= k <= NUM_CH+1, SHALL be output with smp_ch = k-2; words 0 and 1 SHALL be discarded.
REQ-014 Frame end: go to IDLE if stop has been seen since the frame began or mode=1; otherwise start the next frame immediately.
REQ-015 SPI word timing:
- CS falls; 16 SCK periods of 2*SCK_DIV clk each; CS rises CS_GAP cycles before the next word.
- MOSI is updated SCK_DIV cycles before each rising edge.
- MISO is sampled on the clk cycle in which SCK rises.
REQ-016 smp_valid SHALL pulse 1 cycle after CS rises at the end of a retained word.
REQ-017 start, stop and mode SHALL be ignored except as stated; stop in PWRUP, INIT or CAL SHALL be ignored and SHALL NOT be retained.
REQ-018 start held high SHALL NOT re-trigger until the block has returned to IDLE.

Reset
REQ-019 rst SHALL have priority in any state, mid-word included:
- state to IDLE.
- rhd_cs=1, rhd_sck=0, rhd_mosi=0.
- init_done=0, busy=0, smp_valid=0, frame_start=0.
- smp_data=0, smp_ch=0, init_idx=0.
- all counters cleared.

Verification (NUM_CH=4, SCK_DIV=2, CS_GAP=4, PWRUP_CYC=10, N_INIT=3)
REQ-020 rst, then start for 1 cycle: CS stays high 10 cycles; MOSI words seen are init words 0..2, then 0x5500, then 9x 0xFF00; init_done rises; first frame is 0x0000, 0x0100, 0x0200, 0x0300, 0xFF00, 0xFF00.
REQ-021 MISO model returns 0xA000+n on word n of a frame: smp_valid x4 per frame carrying (0xA002, ch0), (0xA003, ch1), (0xA004, ch2), (0xA005, ch3); frame_start with ch0 only.
REQ-022 Word timing: CS low exactly 64 cycles per word; CS high exactly 4 cycles between words; SCK idles low.
REQ-023 mode=1 start after init: exactly one frame, 4 smp_valid, return to IDLE, busy=0, init_done stays 1, no PWRUP.
REQ-024 stop asserted mid-frame in continuous mode: the current frame completes with 4 valid samples, no further CS fall; stop pulsed during INIT is ignored.
REQ-025 rst asserted during bit 7 of a SAMPLE word: the next cycle shows CS=1, SCK=0, init_done=0; a following start repeats PWRUP and INIT.

Source files
------------

// File: rtl/rhd_seq_ctrl.sv
// Sequencer for an RHD-style amplifier chip: power-up wait, register init, calibration,
// then repeating SPI convert frames whose returned ADC words are presented as a sample stream.
module rhd_seq_ctrl #(
   parameter int NUM_CH    = 32,
   parameter int SCK_DIV   = 2,
   parameter int CS_GAP    = 4,
   parameter int PWRUP_CYC = 2000,
   parameter int N_INIT    = 18
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic        mode,
   output logic [5:0]  init_idx,
   input  logic [15:0] init_word,
   output logic        rhd_cs,
   output logic        rhd_sck,
   output logic        rhd_mosi,
   input  logic        rhd_miso,
   output logic        init_done,
   output logic        busy,
   output logic [15:0] smp_data,
   output logic [4:0]  smp_ch,
   output logic        smp_valid,
   output logic        frame_start
);

   localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
   localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam int PWR_W = (PWRUP_CYC > 1) ? $clog2(PWRUP_CYC) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(CS_GAP - 1);
   localparam logic [PWR_W-1:0] PWR_LAST   = PWR_W'(PWRUP_CYC - 1);
   localparam logic [5:0]       INIT_LAST  = 6'(N_INIT - 1);
   localparam logic [5:0]       FRAME_LAST = 6'(NUM_CH + 1);
   localparam logic [5:0]       CAL_LAST   = 6'd9;
   localparam logic [15:0]      CMD_CAL    = 16'h5500;
   localparam logic [15:0]      CMD_DUMMY  = 16'hFF00;

   typedef enum logic [2:0] {
      IDLE,
      PWRUP,
      INIT,
      CAL,
      SAMPLE
   } state_t;

   state_t           state;
   logic [DIV_W-1:0] div_cnt;
   logic [3:0]       bit_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic [PWR_W-1:0] pwr_cnt;
   logic [5:0]       word_cnt;
   logic [15:0]      tx_sh;
   logic [15:0]      rx_sh;
   logic             stop_seen;
   logic             mode_r;
   logic             smp_pend;
   logic             smp_pend_ch0;

   logic [15:0]      tx_word;
   logic             launch;
   logic             word_end;

   always_comb begin
      tx_word = CMD_DUMMY;
      case (state)
         PWRUP, INIT: tx_word = init_word;
         CAL:         tx_word = (word_cnt == 6'd0) ? CMD_CAL : CMD_DUMMY;
         SAMPLE:      tx_word = (word_cnt < 6'(NUM_CH)) ? {2'b00, word_cnt, 8'h00} : CMD_DUMMY;
         default:     tx_word = CMD_DUMMY;
      endcase
   end

   // The first init word is launched on the same edge that leaves PWRUP, so CS stays
   // high for exactly PWRUP_CYC cycles after start; later words wait out the CS gap.
   always_comb begin
      launch = 1'b0;
      if (state == PWRUP)
         launch = (pwr_cnt == PWR_LAST);
      else if (state == INIT || state == CAL || state == SAMPLE)
         launch = rhd_cs && (gap_cnt == GAP_LAST);
   end

   assign word_end = !rhd_cs && rhd_sck && (div_cnt == DIV_LAST) && (bit_cnt == 4'd15);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         rhd_cs       <= 1'b1;
         rhd_sck      <= 1'b0;
         rhd_mosi     <= 1'b0;
         init_done    <= 1'b0;
         busy         <= 1'b0;
         smp_valid    <= 1'b0;
         frame_start  <= 1'b0;
         smp_data     <= 16'h0000;
         smp_ch       <= 5'd0;
         init_idx     <= 6'd0;
         div_cnt      <= '0;
         bit_cnt      <= 4'd0;
         gap_cnt      <= '0;
         pwr_cnt      <= '0;
         word_cnt     <= 6'd0;
         tx_sh        <= 16'h0000;
         rx_sh        <= 16'h0000;
         stop_seen    <= 1'b0;
         mode_r       <= 1'b0;
         smp_pend     <= 1'b0;
         smp_pend_ch0 <= 1'b0;
      end else begin
         smp_valid   <= smp_pend;
         frame_start <= smp_pend && smp_pend_ch0;
         smp_pend    <= 1'b0;

         if (state == SAMPLE && stop)
            stop_seen <= 1'b1;

         // SPI word engine: SCK low half then high half; MOSI moves at the start of the low half
         if (launch) begin
            rhd_cs   <= 1'b0;
            rhd_sck  <= 1'b0;
            rhd_mosi <= tx_word[15];
            tx_sh    <= {tx_word[14:0], 1'b0};
            div_cnt  <= '0;
            bit_cnt  <= 4'd0;
         end else if (!rhd_cs) begin
            if (div_cnt == DIV_LAST) begin
               div_cnt <= '0;
               if (!rhd_sck) begin
                  rhd_sck <= 1'b1;
                  rx_sh   <= {rx_sh[14:0], rhd_miso};
               end else begin
                  rhd_sck <= 1'b0;
                  if (bit_cnt == 4'd15) begin
                     rhd_cs   <= 1'b1;
                     rhd_mosi <= 1'b0;
                     gap_cnt  <= '0;
                  end else begin
                     bit_cnt  <= bit_cnt + 4'd1;
                     rhd_mosi <= tx_sh[15];
                     tx_sh    <= {tx_sh[14:0], 1'b0};
                  end
               end
            end else begin
               div_cnt <= div_cnt + DIV_W'(1);
            end
         end else if (gap_cnt != GAP_LAST) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
         end

         case (state)
            IDLE: begin
               if (start) begin
                  mode_r    <= mode;
                  busy      <= 1'b1;
                  stop_seen <= 1'b0;
                  gap_cnt   <= '0;
                  word_cnt  <= 6'd0;
                  pwr_cnt   <= '0;
                  state     <= init_done ? SAMPLE : PWRUP;
               end
            end
            PWRUP: begin
               if (pwr_cnt == PWR_LAST)
                  state <= INIT;
               else
                  pwr_cnt <= pwr_cnt + PWR_W'(1);
            end
            INIT: begin
               if (word_end) begin
                  if (init_idx == INIT_LAST) begin
                     state    <= CAL;
                     word_cnt <= 6'd0;
                  end else begin
                     init_idx <= init_idx + 6'd1;
                  end
               end
            end
            CAL: begin
               if (word_end) begin
                  if (word_cnt == CAL_LAST) begin
                     init_done <= 1'b1;
                     state     <= SAMPLE;
                     word_cnt  <= 6'd0;
                     stop_seen <= 1'b0;
                  end else begin
                     word_cnt <= word_cnt + 6'd1;
                  end
               end
            end
            SAMPLE: begin
               if (word_end) begin
                  // The reply to CONVERT(c) arrives two words later, so words 0 and 1 carry nothing new
                  if (word_cnt >= 6'd2) begin
                     smp_pend     <= 1'b1;
                     smp_pend_ch0 <= (word_cnt == 6'd2);
                     smp_data     <= rx_sh;
                     smp_ch       <= 5'(word_cnt - 6'd2);
                  end
                  if (word_cnt == FRAME_LAST) begin
                     word_cnt <= 6'd0;
                     if (stop_seen || stop || mode_r) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end else begin
                        stop_seen <= 1'b0;
                     end
                  end else begin
                     word_cnt <= word_cnt + 6'd1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rhd_seq_ctrl.sv
// Bench for rhd_seq_ctrl: an SPI-side monitor plays the chip (MISO model) and checks every
// word and sample against queues filled by the scenario tasks.
module tb_rhd_seq_ctrl;

   localparam int NUM_CH    = 4;
   localparam int SCK_DIV   = 2;
   localparam int CS_GAP    = 4;
   localparam int PWRUP_CYC = 10;
   localparam int N_INIT    = 3;
   localparam int WORD_LOW  = 2 * SCK_DIV * 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        mode = 1'b0;
   logic [5:0]  init_idx;
   logic [15:0] init_word;
   logic        rhd_cs;
   logic        rhd_sck;
   logic        rhd_mosi;
   logic        rhd_miso;
   logic        init_done;
   logic        busy;
   logic [15:0] smp_data;
   logic [4:0]  smp_ch;
   logic        smp_valid;
   logic        frame_start;

   rhd_seq_ctrl #(
      .NUM_CH(NUM_CH), .SCK_DIV(SCK_DIV), .CS_GAP(CS_GAP),
      .PWRUP_CYC(PWRUP_CYC), .N_INIT(N_INIT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
      .init_idx(init_idx), .init_word(init_word),
      .rhd_cs(rhd_cs), .rhd_sck(rhd_sck), .rhd_mosi(rhd_mosi), .rhd_miso(rhd_miso),
      .init_done(init_done), .busy(busy),
      .smp_data(smp_data), .smp_ch(smp_ch), .smp_valid(smp_valid), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] init_val(input logic [5:0] i);
      return 16'h8023 + {2'b00, i, 8'h00} + {10'b0, i};
   endfunction

   assign init_word = init_val(init_idx);

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_mosi[$];
   logic [15:0] exp_miso[$];
   logic [15:0] exp_data[$];
   logic [4:0]  exp_ch[$];

   task automatic push_word(input logic [15:0] m, input logic [15:0] s);
      exp_mosi.push_back(m);
      exp_miso.push_back(s);
   endtask

   task automatic push_init_seq();
      for (int i = 0; i < N_INIT; i++) push_word(init_val(6'(i)), 16'h0000);
      push_word(16'h5500, 16'h0000);
      for (int i = 0; i < 9; i++) push_word(16'hFF00, 16'h0000);
   endtask

   task automatic push_frame();
      for (int n = 0; n < NUM_CH + 2; n++) begin
         push_word((n < NUM_CH) ? {2'b00, 6'(n), 8'h00} : 16'hFF00, 16'hA000 + 16'(n));
         if (n >= 2) begin
            exp_data.push_back(16'hA000 + 16'(n));
            exp_ch.push_back(5'(n - 2));
         end
      end
   endtask

   // Chip-side monitor: drives MISO, captures MOSI on SCK rise, checks framing and samples.
   logic        mon_en = 1'b1;
   logic        prev_cs = 1'b1;
   logic        prev_sck = 1'b0;
   logic        in_word = 1'b0;
   logic        word_ok = 1'b0;
   logic        have_rise = 1'b0;
   logic        gap_busy = 1'b0;
   logic        sck_bad = 1'b0;
   logic        miso_drv = 1'b0;
   logic [15:0] cur_miso = 16'h0000;
   logic [15:0] cap = 16'h0000;
   logic [3:0]  bpos;
   int          low_cnt = 0;
   int          high_cnt = 0;
   int          bit_idx = 0;
   int          smp_seen = 0;

   assign rhd_miso = miso_drv;

   always @(negedge clk) begin
      if (!mon_en) begin
         in_word   = 1'b0;
         have_rise = 1'b0;
         low_cnt   = 0;
         high_cnt  = 0;
         miso_drv  = 1'b0;
      end else begin
         if (prev_cs && !rhd_cs) begin
            if (have_rise && gap_busy) begin
               checks++;
               if (high_cnt !== CS_GAP) begin
                  errors++;
                  $display("FAIL cs_gap: got %0d cycles, expected %0d", high_cnt, CS_GAP);
               end
            end
            in_word = 1'b1;
            low_cnt = 0;
            bit_idx = 0;
            cap     = 16'h0000;
            if (exp_mosi.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: CS fell with %0d words expected", exp_mosi.size());
               word_ok  = 1'b0;
               cur_miso = 16'h0000;
            end else begin
               word_ok  = 1'b1;
               cur_miso = exp_miso[0];
            end
            miso_drv = cur_miso[15];
         end
         if (!rhd_cs) begin
            low_cnt++;
            if (!prev_sck && rhd_sck) begin
               cap = {cap[14:0], rhd_mosi};
               bit_idx++;
               bpos = 4'(15 - bit_idx);
               miso_drv = (bit_idx < 16) ? cur_miso[bpos] : 1'b0;
            end
         end
         if (!prev_cs && rhd_cs && in_word) begin
            in_word   = 1'b0;
            have_rise = 1'b1;
            high_cnt  = 0;
            gap_busy  = 1'b1;
            checks++;
            if (low_cnt !== WORD_LOW) begin
               errors++;
               $display("FAIL cs_low: got %0d cycles, expected %0d", low_cnt, WORD_LOW);
            end
            checks++;
            if (rhd_sck !== 1'b0) begin
               errors++;
               $display("FAIL sck_after_word: got %b, expected 0", rhd_sck);
            end
            if (word_ok) begin
               checks++;
               if (cap !== exp_mosi[0]) begin
                  errors++;
                  $display("FAIL mosi_word: got %h, expected %h", cap, exp_mosi[0]);
               end
               void'(exp_mosi.pop_front());
               void'(exp_miso.pop_front());
            end
         end
         if (rhd_cs) begin
            high_cnt++;
            gap_busy = gap_busy & busy;
            if (rhd_sck !== 1'b0) sck_bad = 1'b1;
         end
         if (smp_valid) begin
            smp_seen++;
            checks++;
            if (exp_data.size() == 0) begin
               errors++;
               $display("FAIL unexpected_sample: got data %h ch %0d, expected none", smp_data, smp_ch);
            end else begin
               if (smp_data !== exp_data[0] || smp_ch !== exp_ch[0] || frame_start !== (exp_ch[0] == 5'd0)) begin
                  errors++;
                  $display("FAIL sample: got data %h ch %0d fs %b, expected data %h ch %0d fs %b",
                           smp_data, smp_ch, frame_start, exp_data[0], exp_ch[0], exp_ch[0] == 5'd0);
               end
               void'(exp_data.pop_front());
               void'(exp_ch.pop_front());
            end
         end else if (frame_start) begin
            checks++;
            errors++;
            $display("FAIL frame_start_alone: got 1 without smp_valid, expected 0");
         end
      end
      prev_cs  = rhd_cs;
      prev_sck = rhd_sck;
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (rhd_cs !== 1'b1)       begin errors++; $display("FAIL rst_cs: got %b, expected 1", rhd_cs); end
      checks++; if (rhd_sck !== 1'b0)      begin errors++; $display("FAIL rst_sck: got %b, expected 0", rhd_sck); end
      checks++; if (rhd_mosi !== 1'b0)     begin errors++; $display("FAIL rst_mosi: got %b, expected 0", rhd_mosi); end
      checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
      checks++; if (init_done !== 1'b0)    begin errors++; $display("FAIL rst_init_done: got %b, expected 0", init_done); end
      checks++; if (smp_valid !== 1'b0)    begin errors++; $display("FAIL rst_smp_valid: got %b, expected 0", smp_valid); end
      checks++; if (frame_start !== 1'b0)  begin errors++; $display("FAIL rst_frame_start: got %b, expected 0", frame_start); end
      checks++; if (smp_data !== 16'h0000) begin errors++; $display("FAIL rst_smp_data: got %h, expected 0000", smp_data); end
      checks++; if (smp_ch !== 5'd0)       begin errors++; $display("FAIL rst_smp_ch: got %0d, expected 0", smp_ch); end
      checks++; if (init_idx !== 6'd0)     begin errors++; $display("FAIL rst_init_idx: got %0d, expected 0", init_idx); end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_init_continuous();
      int  lat;
      logic got;
      smp_seen = 0;
      push_init_seq();
      push_frame();
      push_frame();
      start = 1'b1;
      mode  = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL init_busy: got %b, expected 1", busy); end
      lat = 0;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); #1;
         if (!rhd_cs) begin lat = k; break; end
      end
      checks++; if (lat !== PWRUP_CYC) begin errors++; $display("FAIL pwrup_len: got %0d, expected %0d", lat, PWRUP_CYC); end
      // stop pulsed while init words are going out must be forgotten
      repeat (70) @(posedge clk);
      #1 stop = 1'b1;
      @(posedge clk);
      #1 stop = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         @(posedge clk); #1;
         if (init_done) begin got = 1'b1; break; end
      end
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL init_done_rise: got %b, expected 1", got); end
      got = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         @(posedge clk); #1;
         if (smp_seen >= NUM_CH) begin got = 1'b1; break; end
      end
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL first_frame: got %0d samples, expected %0d", smp_seen, NUM_CH); end
      repeat (100) @(posedge clk);
      #1 stop = 1'b1;
      @(posedge clk);
      #1 stop = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         @(posedge clk); #1;
         if (!busy) begin got = 1'b1; break; end
      end
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL stop_idle: got busy %b, expected 0", busy); end
      repeat (100) @(posedge clk);
      #1;
      checks++; if (exp_mosi.size() !== 0) begin errors++; $display("FAIL cont_words_left: got %0d, expected 0", exp_mosi.size()); end
      checks++; if (exp_data.size() !== 0) begin errors++; $display("FAIL cont_samples_left: got %0d, expected 0", exp_data.size()); end
      checks++; if (smp_seen !== 2 * NUM_CH) begin errors++; $display("FAIL cont_sample_count: got %0d, expected %0d", smp_seen, 2 * NUM_CH); end
      checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL cont_init_done: got %b, expected 1", init_done); end
   endtask

   task automatic test_single_frame();
      int  lat;
      logic got;
      smp_seen = 0;
      push_frame();
      start = 1'b1;
      mode  = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b, expected 1", busy); end
      lat = 0;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); #1;
         if (!rhd_cs) begin lat = k; break; end
      end
      checks++; if (lat !== CS_GAP) begin errors++; $display("FAIL single_latency: got %0d, expected %0d", lat, CS_GAP); end
      // start stays high well into the frame; it must not restart anything
      repeat (300) @(posedge clk);
      #1 start = 1'b0;
      mode = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         @(posedge clk); #1;
         if (!busy) begin got = 1'b1; break; end
      end
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL single_idle: got busy %b, expected 0", busy); end
      repeat (50) @(posedge clk);
      #1;
      checks++; if (exp_mosi.size() !== 0) begin errors++; $display("FAIL single_words_left: got %0d, expected 0", exp_mosi.size()); end
      checks++; if (smp_seen !== NUM_CH) begin errors++; $display("FAIL single_sample_count: got %0d, expected %0d", smp_seen, NUM_CH); end
      checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL single_init_done: got %b, expected 1", init_done); end
   endtask

   task automatic test_reset_mid_word();
      int  lat;
      logic got;
      mon_en = 1'b0;
      start  = 1'b1;
      mode   = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #1;
         if (!rhd_cs) begin got = 1'b1; break; end
      end
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL midrst_word_start: got cs %b, expected 0", rhd_cs); end
      repeat (29) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (rhd_cs !== 1'b1)    begin errors++; $display("FAIL midrst_cs: got %b, expected 1", rhd_cs); end
      checks++; if (rhd_sck !== 1'b0)   begin errors++; $display("FAIL midrst_sck: got %b, expected 0", rhd_sck); end
      checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL midrst_init_done: got %b, expected 0", init_done); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy: got %b, expected 0", busy); end
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      mon_en   = 1'b1;
      smp_seen = 0;
      push_init_seq();
      push_frame();
      start = 1'b1;
      mode  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); #1;
         if (!rhd_cs) begin lat = k; break; end
      end
      checks++; if (lat !== PWRUP_CYC) begin errors++; $display("FAIL repwrup_len: got %0d, expected %0d", lat, PWRUP_CYC); end
      got = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(posedge clk); #1;
         if (!busy) begin got = 1'b1; break; end
      end
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL reinit_idle: got busy %b, expected 0", busy); end
      repeat (50) @(posedge clk);
      #1;
      mode = 1'b0;
      checks++; if (exp_mosi.size() !== 0) begin errors++; $display("FAIL reinit_words_left: got %0d, expected 0", exp_mosi.size()); end
      checks++; if (smp_seen !== NUM_CH) begin errors++; $display("FAIL reinit_sample_count: got %0d, expected %0d", smp_seen, NUM_CH); end
      checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL reinit_init_done: got %b, expected 1", init_done); end
      checks++; if (sck_bad !== 1'b0) begin errors++; $display("FAIL sck_idle: got sck high with CS high, expected low"); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_init_continuous();
      test_single_frame();
      test_reset_mid_word();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
